// File: rtl/spi_target.sv
// SPI mode-0 target with synchronized inputs, one-entry TX holding register and RX valid/ready.
// Optional SPI_TARGET_LOOPBACK_EN: an empty holding register echoes the last completed RX byte.
module spi_target #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_FILL   = 8'hFF
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_ss_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  input  logic              status_clr,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    WAIT_DESEL = 2'd0,
    IDLE       = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  state_t                  state_r, state_next_s;
  logic [SYNC_STAGES-1:0]  sclk_sync_r, mosi_sync_r, ss_sync_r;
  logic                    sclk_prev_r, ss_prev_r;
  logic                    sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s, ss_last_s;
  logic                    in_active_s, consume_s, rx_done_s, underrun_evt_s;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic                    pending_r;
  logic [DATA_W-1:0]       tx_shift_r, tx_src_s, hold_r, rx_byte_s, rx_data_r;
  logic [DATA_W-2:0]       rx_shift_r;
  logic                    oe_r, busy_r, tx_ready_r, rx_valid_r, rx_overrun_r, tx_underrun_r;
`ifdef SPI_TARGET_LOOPBACK_EN
  logic [DATA_W-1:0]       last_rx_r;
  logic                    have_rx_r;
`endif

  assign ss_last_s   = ss_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-1] & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_sync_r[SYNC_STAGES-1] & sclk_prev_r;
  assign ss_rise_s   = ss_last_s & ~ss_prev_r;
  assign ss_fall_s   = ~ss_last_s & ss_prev_r;

  // Deselect takes priority over any SCLK edge seen in the same cycle.
  assign in_active_s = (state_r == ACTIVE) && !ss_rise_s;
  assign consume_s   = ((state_r == IDLE) && ss_fall_s) || (in_active_s && sclk_fall_s && pending_r);
  assign rx_done_s   = in_active_s && sclk_rise_s && (bit_cnt_r == LAST_BIT);
  assign rx_byte_s   = {rx_shift_r, mosi_sync_r[SYNC_STAGES-1]};

  // Selects the byte loaded into the shifter at a frame start or byte boundary.
  always_comb begin
    tx_src_s       = IDLE_FILL;
    underrun_evt_s = 1'b0;
    if (!tx_ready_r) begin
      tx_src_s = hold_r;
    end else begin
`ifdef SPI_TARGET_LOOPBACK_EN
      if (have_rx_r) begin
        tx_src_s = last_rx_r;
      end else begin
        tx_src_s = IDLE_FILL;
      end
`else
      tx_src_s       = IDLE_FILL;
      underrun_evt_s = consume_s;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_r <= WAIT_DESEL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; after reset a frame is only accepted once SS_n has been seen high.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      WAIT_DESEL: if (ss_last_s) state_next_s = IDLE;   else state_next_s = WAIT_DESEL;
      IDLE:       if (ss_fall_s) state_next_s = ACTIVE; else state_next_s = IDLE;
      ACTIVE:     if (ss_rise_s) state_next_s = IDLE;   else state_next_s = ACTIVE;
      default:    state_next_s = WAIT_DESEL;
    endcase
  end

  // SPI-side datapath: synchronizers, bit counter and shift registers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      ss_sync_r   <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
      ss_prev_r   <= 1'b0;
      bit_cnt_r   <= {CNT_W{1'b0}};
      pending_r   <= 1'b0;
      tx_shift_r  <= {DATA_W{1'b1}};
      rx_shift_r  <= {(DATA_W-1){1'b0}};
      oe_r        <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], spi_ss_n};
      sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
      ss_prev_r   <= ss_last_s;
      busy_r      <= (state_next_s == ACTIVE);
      if ((state_r == IDLE) && ss_fall_s) begin
        tx_shift_r <= tx_src_s;
        oe_r       <= 1'b1;
        bit_cnt_r  <= {CNT_W{1'b0}};
        pending_r  <= 1'b0;
      end else if ((state_r == ACTIVE) && ss_rise_s) begin
        // Partial byte is dropped silently; MISO idles high.
        tx_shift_r <= {DATA_W{1'b1}};
        oe_r       <= 1'b0;
        bit_cnt_r  <= {CNT_W{1'b0}};
        pending_r  <= 1'b0;
      end else if (in_active_s && sclk_rise_s) begin
        rx_shift_r <= rx_byte_s[DATA_W-2:0];
        if (bit_cnt_r == LAST_BIT) begin
          bit_cnt_r <= {CNT_W{1'b0}};
          pending_r <= 1'b1;
        end else begin
          bit_cnt_r <= bit_cnt_r + CNT_ONE;
        end
      end else if (in_active_s && sclk_fall_s) begin
        if (pending_r) begin
          tx_shift_r <= tx_src_s;
          pending_r  <= 1'b0;
        end else begin
          tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b1};
        end
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Fabric-side registers: TX holding register, RX data handshake and sticky flags.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hold_r        <= {DATA_W{1'b0}};
      tx_ready_r    <= 1'b1;
      rx_data_r     <= {DATA_W{1'b0}};
      rx_valid_r    <= 1'b0;
      rx_overrun_r  <= 1'b0;
      tx_underrun_r <= 1'b0;
`ifdef SPI_TARGET_LOOPBACK_EN
      last_rx_r     <= {DATA_W{1'b0}};
      have_rx_r     <= 1'b0;
`endif
    end else begin
      if (tx_valid && tx_ready_r) begin
        hold_r     <= tx_data;
        tx_ready_r <= 1'b0;
      end else if (consume_s && !tx_ready_r) begin
        tx_ready_r <= 1'b1;
      end else begin
        tx_ready_r <= tx_ready_r;
      end
      if (rx_done_s) begin
`ifdef SPI_TARGET_LOOPBACK_EN
        last_rx_r <= rx_byte_s;
        have_rx_r <= 1'b1;
`endif
        if (!rx_valid_r || rx_ready) begin
          rx_data_r  <= rx_byte_s;
          rx_valid_r <= 1'b1;
        end
      end else if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
      // Set wins over a coincident clear.
      rx_overrun_r  <= (rx_done_s && rx_valid_r && !rx_ready) || (rx_overrun_r && !status_clr);
      tx_underrun_r <= underrun_evt_s || (tx_underrun_r && !status_clr);
    end
  end

  assign spi_miso    = tx_shift_r[DATA_W-1];
  assign spi_miso_oe = oe_r;
  assign tx_ready    = tx_ready_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign rx_overrun  = rx_overrun_r;
  assign tx_underrun = tx_underrun_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_spi_target.sv
// Directed self-checking bench for spi_target: SPI master model at SCLK = clk/8.
module tb_spi_target;

  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_overrun, tx_underrun;
  logic       status_clr = 1'b0;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef SPI_TARGET_LOOPBACK_EN
  localparam logic [7:0] EXP_FILL = 8'h3C;
  localparam logic       EXP_UND  = 1'b0;
`else
  localparam logic [7:0] EXP_FILL = 8'hFF;
  localparam logic       EXP_UND  = 1'b1;
`endif

  spi_target dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
    .status_clr(status_clr), .busy(busy)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic select();
    spi_ss_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic deselect();
    wait_clk(4);
    spi_ss_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic pulse_rx_ready();
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_status_clr();
    status_clr = 1'b1;
    wait_clk(1);
    status_clr = 1'b0;
  endtask

  task automatic load_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  // mode 1: check rx_valid latency on the last rising edge; mode 2: pulse rx_ready as the byte completes
  task automatic xfer(input logic [7:0] mo, input int mode, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = mo[i];
      wait_clk(4);
      mi[i] = spi_miso;
      spi_sclk = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk_clk);
        if (i == 0 && mode == 1 && k == 2) begin
          tests_run++;
          if (rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rx_valid_early: got %b expected 0 two cycles after last rise", rx_valid);
          end
        end
        if (i == 0 && mode == 1 && k == 3) begin
          tests_run++;
          if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL rx_valid_latency: got valid=%b data=%h expected valid=1 data=3c", rx_valid, rx_data);
          end
        end
        if (i == 0 && mode == 2 && k == 2) rx_ready = 1'b1;
        if (i == 0 && mode == 2 && k == 3) rx_ready = 1'b0;
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic sclk_edges(input int n);
    spi_mosi = 1'b1;
    for (int e = 0; e < n; e++) begin
      spi_sclk = ~spi_sclk;
      wait_clk(4);
    end
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    wait_clk(2);
    reset_reset = 1'b0;
    tests_run++;
    if ({spi_miso, spi_miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, busy} !== 7'b1010000
        || rx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_values: got miso=%b oe=%b txr=%b rxv=%b ovr=%b und=%b busy=%b rxd=%h expected 1 0 1 0 0 0 0 00",
               spi_miso, spi_miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, busy, rx_data);
    end
    wait_clk(6);
  endtask

  task automatic test_basic_frame();
    logic [7:0] mi;
    load_tx(8'hA5);
    tests_run++;
    if (tx_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL tx_ready_after_load: got %b expected 0", tx_ready);
    end
    select();
    tests_run++;
    if (busy !== 1'b1 || spi_miso_oe !== 1'b1 || tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_start: got busy=%b oe=%b txr=%b expected 1 1 1", busy, spi_miso_oe, tx_ready);
    end
    xfer(8'h3C, 1, mi);
    tests_run++;
    if (mi !== 8'hA5) begin
      tests_failed++;
      $display("FAIL basic_miso: got %h expected a5", mi);
    end
    deselect();
    tests_run++;
    if (busy !== 1'b0 || spi_miso_oe !== 1'b0 || spi_miso !== 1'b1 || rx_data !== 8'h3C || rx_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_end: got busy=%b oe=%b miso=%b rxd=%h rxv=%b expected 0 0 1 3c 1",
               busy, spi_miso_oe, spi_miso, rx_data, rx_valid);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    pulse_rx_ready();
    tests_run++;
    if (rx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_accept: got rx_valid=%b expected 0", rx_valid);
    end
    select();
    xfer(8'h96, 0, mi);
    deselect();
    tests_run++;
    if (mi !== EXP_FILL || tx_underrun !== EXP_UND || rx_data !== 8'h96) begin
      tests_failed++;
      $display("FAIL underrun_frame: got miso=%h und=%b rxd=%h expected %h %b 96", mi, tx_underrun, rx_data, EXP_FILL, EXP_UND);
    end
    pulse_status_clr();
    tests_run++;
    if (tx_underrun !== 1'b0 || rx_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL status_clr: got und=%b ovr=%b expected 0 0", tx_underrun, rx_overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2;
    pulse_rx_ready();
    load_tx(8'h5A);
    select();
    load_tx(8'h11);
    xfer(8'h81, 0, m1);
    xfer(8'h7E, 0, m2);
    deselect();
    tests_run++;
    if (m1 !== 8'h5A || m2 !== 8'h11) begin
      tests_failed++;
      $display("FAIL b2b_miso: got %h %h expected 5a 11", m1, m2);
    end
    tests_run++;
    if (rx_data !== 8'h81 || rx_valid !== 1'b1 || rx_overrun !== 1'b1 || tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_rx: got rxd=%h rxv=%b ovr=%b txr=%b expected 81 1 1 1", rx_data, rx_valid, rx_overrun, tx_ready);
    end
  endtask

  task automatic test_partial();
    logic [7:0] mi;
    pulse_rx_ready();
    select();
    sclk_edges(5);
    spi_ss_n = 1'b1;
    wait_clk(6);
    spi_sclk = 1'b0;
    wait_clk(4);
    tests_run++;
    if (rx_valid !== 1'b0 || busy !== 1'b0 || spi_miso_oe !== 1'b0 || spi_miso !== 1'b1) begin
      tests_failed++;
      $display("FAIL partial_abort: got rxv=%b busy=%b oe=%b miso=%b expected 0 0 0 1", rx_valid, busy, spi_miso_oe, spi_miso);
    end
    select();
    xfer(8'hC3, 0, mi);
    deselect();
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin
      tests_failed++;
      $display("FAIL partial_next: got rxv=%b rxd=%h expected 1 c3", rx_valid, rx_data);
    end
  endtask

  task automatic test_same_cycle_accept();
    logic [7:0] mi;
    pulse_status_clr();
    select();
    xfer(8'h5A, 2, mi);
    deselect();
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h5A || rx_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle_accept: got rxv=%b rxd=%h ovr=%b expected 1 5a 0", rx_valid, rx_data, rx_overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] mi;
    load_tx(8'h77);
    select();
    sclk_edges(5);
    reset_reset = 1'b1;
    wait_clk(1);
    reset_reset = 1'b0;
    tests_run++;
    if ({spi_miso, spi_miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, busy} !== 7'b1010000
        || rx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_frame: got miso=%b oe=%b txr=%b rxv=%b ovr=%b und=%b busy=%b rxd=%h expected 1 0 1 0 0 0 0 00",
               spi_miso, spi_miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, busy, rx_data);
    end
    spi_sclk = 1'b0;
    wait_clk(4);
    xfer(8'hE7, 0, mi);
    wait_clk(4);
    tests_run++;
    if (rx_valid !== 1'b0 || busy !== 1'b0 || spi_miso_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_ignored: got rxv=%b busy=%b oe=%b expected 0 0 0", rx_valid, busy, spi_miso_oe);
    end
    spi_ss_n = 1'b1;
    wait_clk(6);
    select();
    xfer(8'h24, 0, mi);
    deselect();
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h24) begin
      tests_failed++;
      $display("FAIL post_reset_frame: got rxv=%b rxd=%h expected 1 24", rx_valid, rx_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun();
    test_back_to_back();
    test_partial();
    test_same_cycle_accept();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI responder (mode 0, MSB first); the far end of the SoC's spi0 master (SCLK/MOSI/SS_n driven in, MISO driven out).
- Used to emulate an SPI peripheral in fabric and as a loopback partner for bring-up and benches.
- Oversamples the SPI lines on the system clock.
- Exchanges bytes with fabric logic through a one-entry TX holding register and an RX data register with a valid/ready handshake.

Parameters:
DATA_W, 8, frame width in bits
SYNC_STAGES, 2, synchronizer flops on SCLK, MOSI and SS_n (minimum 2)
IDLE_FILL, 8'hFF, byte shifted out when no TX data is held (width DATA_W)

Ports:
clk_clk  in  1  system clock; must be at least 8x SCLK frequency
reset_reset  in  1  synchronous, active-high reset
spi_sclk  in  1  SPI clock from master
spi_mosi  in  1  master-out data
spi_ss_n  in  1  active-low select
spi_miso  out  1  target-out data
spi_miso_oe  out  1  MISO drive enable; tristate at top level
tx_data  in  DATA_W  next byte to send
tx_valid  in  1  tx_data offered
tx_ready  out  1  holding register empty
rx_data  out  DATA_W  last received byte
rx_valid  out  1  rx_data valid; held until accepted
rx_ready  in  1  consumer accepts rx_data
rx_overrun  out  1  sticky: byte dropped because rx_valid was still high
tx_underrun  out  1  sticky: IDLE_FILL sent because holding register was empty
status_clr  in  1  clears both sticky flags
busy  out  1  frame in progress (state ACTIVE)

Behaviour:
- Reset is synchronous and active-high on clk_clk; one clock.
- Reset values: spi_miso=1, spi_miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, rx_overrun=0, tx_underrun=0, busy=0. Holding register empty; state WAIT_DESEL.
- Synchronization: SCLK, MOSI and SS_n each pass through SYNC_STAGES flops. Edges are detected by comparing the last synced sample with the one before it. Edge-to-action latency is SYNC_STAGES+1 clk_clk cycles.
- States:
  - WAIT_DESEL: entered after reset. Goes to IDLE once synced SS_n=1. A frame already in progress at reset is therefore ignored entirely.
  - IDLE: on synced SS_n falling edge, load tx_shift and go to ACTIVE. If the holding register is full, load it and free it; otherwise load IDLE_FILL and set tx_underrun. Set spi_miso_oe=1 and spi_miso=tx_shift MSB. Clear bit_cnt to 0.
  - ACTIVE: busy=1.
    - SCLK rising: rx_shift <= {rx_shift[DATA_W-2:0], mosi}; bit_cnt++.
    - When bit_cnt reaches DATA_W on a rising edge, the byte is complete:
      - if rx_valid=0, rx_data <= assembled byte and rx_valid=1 on the next cycle;
      - otherwise drop the byte and set rx_overrun.
      - bit_cnt returns to 0 and a pending_load flag is set.
    - SCLK falling: if pending_load is set, load tx_shift using the same rule as frame start and clear pending_load; otherwise shift tx_shift left by one. spi_miso tracks tx_shift MSB.
    - Synced SS_n rising edge: go to IDLE; spi_miso_oe=0, spi_miso=1.
      - A partial byte (bit_cnt != 0) is discarded with no rx_valid and no flag.
      - Holding register contents are preserved.
- rx handshake: rx_valid&&rx_ready clears rx_valid next cycle. If a byte completes in the same cycle as acceptance, the new byte is stored with no overrun.
- tx handshake: tx_valid&&tx_ready loads the holding register; tx_ready=0 next cycle. If a load and a consume happen in the same cycle, the consume takes the old contents and the new data lands; tx_ready stays 0.
- status_clr clears both sticky flags. If status_clr coincides with a new overrun/underrun event, the flag ends up set (set wins).
- SCLK edges while SS_n is high are ignored.
- bit_cnt width is clog2(DATA_W)+1; no wrap beyond DATA_W.

Optional Feature:
- SPI_TARGET_LOOPBACK_EN defined: when the holding register is empty at a load point, the last completed rx byte is sent instead of IDLE_FILL (IDLE_FILL if no byte has been received since reset), and tx_underrun is not set.
- Undefined: IDLE_FILL is sent and tx_underrun is set, as specified above.

Test Plan:
- Reset, SS_n=1, tx_data=8'hA5 loaded, then one 8-bit frame with MOSI=8'h3C at SCLK=clk/8 -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with rx_valid 3 cycles after the 8th rising edge; tx_ready=1 after SS_n falls.
- Two back-to-back bytes in one SS_n frame, holding register refilled with 8'h11 mid-byte, rx_ready held 0 -> second byte's MISO=8'h11; second rx byte dropped; rx_overrun=1; rx_data keeps the first byte.
- Frame with empty holding register -> MISO=8'hFF, tx_underrun=1; status_clr pulse -> 0. With SPI_TARGET_LOOPBACK_EN, MISO equals the previous rx byte and tx_underrun stays 0.
- SS_n raised after 5 SCLK edges -> no rx_valid, busy=0, spi_miso_oe=0; next full frame receives correctly.
- reset_reset pulsed mid-frame with SS_n low -> outputs at reset values; no rx_valid from remaining edges until SS_n goes high and then low again.
- rx_ready asserted in the same cycle a new byte completes -> new byte stored, rx_valid stays 1, rx_overrun=0.
